// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the N-requester priority arbiter.
package prio_arb_pkg;

  // Widest requester vector the one-hot helper can produce.
  localparam int ARB_MAX_N = 64;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // One-hot decode of an index; callers size-cast the result down to N bits.
  function automatic logic [ARB_MAX_N-1:0] onehot_of(input int unsigned idx);
    logic [ARB_MAX_N-1:0] one;
    one = {{(ARB_MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational lowest-set-bit encoder: y is the index of the lowest set bit
// of x, f flags that at least one bit is set (y is 0 when f is 0).
module prio_enc_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         f
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    y = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i]) y = W'(i);
    end
  end

  assign f = |x;

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered, handshaked N-requester arbiter with a hold watchdog.
// Optional build macro ROUND_ROBIN_EN: selection starts from a rotating
// pointer instead of always favouring requester 0.
module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0]    enc_x;
  logic [W-1:0]    enc_y;
  logic            enc_f;
  logic [W-1:0]    sel_idx;
  logic            owner_req;
  logic            hold_expired;
  logic            grant_exit;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0]    ptr_q, ptr_d;
  logic [W:0]      sel_sum;

  // Rotate requests so the pointer position lands on bit 0 of the encoder.
  assign enc_x = N'({req, req} >> ptr_q);

  // Map the rotated winner back to a real requester index, modulo N.
  always_comb begin
    sel_sum = {1'b0, enc_y} + {1'b0, ptr_q};
    if (sel_sum >= (W+1)'(N)) sel_idx = W'(sel_sum - (W+1)'(N));
    else                      sel_idx = W'(sel_sum);
  end

  // Pointer moves just past the owner whenever a grant ends.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ARB_GRANT && grant_exit) begin
      if (gnt_idx_q == W'(N - 1)) ptr_d = '0;
      else                        ptr_d = gnt_idx_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign enc_x   = req;
  assign sel_idx = enc_y;
`endif

  prio_enc_n #(
    .N (N),
    .W (W)
  ) u_enc (
    .x (enc_x),
    .y (enc_y),
    .f (enc_f)
  );

  assign owner_req    = req[gnt_idx_q];
  assign hold_expired = (cnt_q == CW'(TIMEOUT - 1));
  assign grant_exit   = ack || !owner_req || hold_expired;

  // Next-state and registered-output logic for the IDLE/GRANT handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_valid_d  = 1'b0;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
        cnt_d        = '0;
        if (enc_f) begin
          state_d      = ARB_GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = sel_idx;
          gnt_onehot_d = N'(onehot_of(32'(sel_idx)));
        end
      end
      ARB_GRANT: begin
        if (grant_exit) begin
          state_d      = ARB_IDLE;
          gnt_valid_d  = 1'b0;
          gnt_idx_d    = '0;
          gnt_onehot_d = '0;
          cnt_d        = '0;
          // An ack in the same cycle as expiry counts as a clean release.
          timeout_d    = hold_expired && !ack;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, hold counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      timeout_q    <= timeout_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Self-checking bench for prio_arbiter_n (N=8/TIMEOUT=16 and N=5/TIMEOUT=4).
// Expectations follow the ROUND_ROBIN_EN build macro when it is defined.
module tb_prio_arbiter_n;

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic       gv;
  logic [2:0] gi;
  logic [7:0] go;
  logic       to;

  logic [4:0] req5;
  logic       ack5;
  logic       gv5;
  logic [2:0] gi5;
  logic [4:0] go5;
  logic       to5;

  always #5 clk = ~clk;

  prio_arbiter_n #(.N(8), .TIMEOUT(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (gv),
    .gnt_idx    (gi),
    .gnt_onehot (go),
    .timeout    (to)
  );

  prio_arbiter_n #(.N(5), .TIMEOUT(4)) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .req        (req5),
    .ack        (ack5),
    .gnt_valid  (gv5),
    .gnt_idx    (gi5),
    .gnt_onehot (go5),
    .timeout    (to5)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t sb5[$];
  exp_t e;
  vec_t tbl[22];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle on the N=8 instance; expectation is for the outputs after the edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic a,
                      input logic ev, input logic [2:0] ei, input logic [7:0] eo,
                      input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; req = rq; ack = a;
    sb.push_back('{ev, ei, eo, et, nm});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.nm, ".valid"},   32'(gv), 32'(x.v));
    chk({x.nm, ".idx"},     32'(gi), 32'(x.idx));
    chk({x.nm, ".onehot"},  32'(go), 32'(x.oh));
    chk({x.nm, ".timeout"}, 32'(to), 32'(x.to));
  endtask

  // Same for the N=5 instance.
  task automatic step5(input logic [4:0] rq, input logic a,
                       input logic ev, input logic [2:0] ei, input logic [4:0] eo,
                       input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    req5 = rq; ack5 = a;
    sb5.push_back('{ev, ei, {3'b000, eo}, et, nm});
    @(posedge clk);
    #1;
    x = sb5.pop_front();
    chk({x.nm, ".valid"},   32'(gv5), 32'(x.v));
    chk({x.nm, ".idx"},     32'(gi5), 32'(x.idx));
    chk({x.nm, ".onehot"},  32'(go5), 32'(x.oh[4:0]));
    chk({x.nm, ".timeout"}, 32'(to5), 32'(x.to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    //            rst   req    ack   v     idx                 oh                       to
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[1]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 3'd0,               8'h01,                   1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[3]  = '{1'b0, 8'hA0, 1'b0, 1'b1, 3'd5,               8'h20,                   1'b0};
    tbl[4]  = '{1'b0, 8'hA0, 1'b0, 1'b1, 3'd5,               8'h20,                   1'b0};
    tbl[5]  = '{1'b0, 8'hA0, 1'b0, 1'b1, 3'd5,               8'h20,                   1'b0};
    tbl[6]  = '{1'b0, 8'hA0, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[7]  = '{1'b0, 8'hA0, 1'b0, 1'b1, RR ? 3'd7 : 3'd5,   RR ? 8'h80 : 8'h20,      1'b0};
    tbl[8]  = '{1'b0, 8'hA0, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[9]  = '{1'b0, 8'h44, 1'b0, 1'b1, 3'd2,               8'h04,                   1'b0};
    tbl[10] = '{1'b0, 8'h44, 1'b0, 1'b1, 3'd2,               8'h04,                   1'b0};
    tbl[11] = '{1'b0, 8'h40, 1'b0, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[12] = '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6,               8'h40,                   1'b0};
    tbl[13] = '{1'b0, 8'h40, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[16] = '{1'b0, 8'h10, 1'b0, 1'b1, 3'd4,               8'h10,                   1'b0};
    tbl[17] = '{1'b0, 8'h11, 1'b0, 1'b1, 3'd4,               8'h10,                   1'b0};
    tbl[18] = '{1'b0, 8'h13, 1'b0, 1'b1, 3'd4,               8'h10,                   1'b0};
    tbl[19] = '{1'b0, 8'h13, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};
    tbl[20] = '{1'b0, 8'h13, 1'b0, 1'b1, 3'd0,               8'h01,                   1'b0};
    tbl[21] = '{1'b0, 8'h13, 1'b1, 1'b0, 3'd0,               8'h00,                   1'b0};

    rst = 1'b0; req = 8'h00; ack = 1'b0; req5 = 5'd0; ack5 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.valid",  32'(gv), 32'd0);
    chk("async_rst.onehot", 32'(go), 32'd0);
    chk("async_rst.timeout", 32'(to), 32'd0);

    // Table: reset, first grant, ack hold, bubble, drop, ignored req changes.
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].v, tbl[i].idx, tbl[i].oh,
           tbl[i].to, $sformatf("vec%0d", i));
    end

    // Watchdog: 16 grant cycles, pulse on exit, re-grant after the bubble.
    for (int c = 0; c < 16; c++) step(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, $sformatf("hold%0d", c));
    step(1'b0, 8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, "to_exit");
    step(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, "to_regrant");
    step(1'b0, 8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "to_release");

    // Ack on the expiry cycle suppresses the timeout pulse.
    for (int c = 0; c < 16; c++) step(1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, $sformatf("ackto%0d", c));
    step(1'b0, 8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "ackto_exit");
    step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, "ackto_after");

    // All requesting, ack every grant: rotates in round-robin, stays at 0 otherwise.
    step(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, "rr_rst");
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 8'hFF, 1'b0, 1'b1, RR ? 3'(k % 8) : 3'd0,
           RR ? 8'(8'h01 << (k % 8)) : 8'h01, 1'b0, $sformatf("rr_g%0d", k));
      step(1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, $sformatf("rr_a%0d", k));
    end
    step(1'b0, 8'hFF, 1'b0, 1'b1, RR ? 3'd1 : 3'd0, RR ? 8'h02 : 8'h01, 1'b0, "pre_rst_grant");

    // Reset mid-grant drops everything without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.valid",  32'(gv), 32'd0);
    chk("midrst.idx",    32'(gi), 32'd0);
    chk("midrst.onehot", 32'(go), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, "midrst_hold");
    step(1'b0, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0, "post_rst_grant");
    step(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, "post_rst_ack");

    // N=5, TIMEOUT=4: top requester, watchdog, then a mixed vector.
    for (int c = 0; c < 4; c++) step5(5'b10000, 1'b0, 1'b1, 3'd4, 5'b10000, 1'b0, $sformatf("n5_hold%0d", c));
    step5(5'b10000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b1, "n5_to");
    step5(5'b10000, 1'b0, 1'b1, 3'd4, 5'b10000, 1'b0, "n5_regrant");
    step5(5'b10000, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, "n5_ack");
    step5(5'b10110, 1'b0, 1'b1, 3'd1, 5'b00010, 1'b0, "n5_mixed");
    step5(5'b10110, 1'b1, 1'b0, 3'd0, 5'b00000, 1'b0, "n5_mixed_ack");
    step5(5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000, 1'b0, "n5_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
